// File: rtl/trap_sequencer.sv
// Interrupt front-end: synchronises IRQ lines, latches rising edges as
// pending, and sequences trap entry (redirect to MTVEC) and MRET return
// (redirect to MEPC) around a single non-nesting handler.
module trap_sequencer #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               csrMie_i,
    input  logic [31:0]        csrMtvec_i,
    input  logic [31:0]        csrMepc_i,
    input  logic               instrRetire_i,
    input  logic               mret_i,
    output logic               intTaken_o,
    output logic               stall_o,
    output logic               pcSel_o,
    output logic [31:0]        pcRedirect_o,
    output logic               intActive_o,
    output logic [CW-1:0]      intCause_o,
    output logic [NUM_SRC-1:0] pending_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAKE,
        S_HANDLER,
        S_RETURN
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] syncChain_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prevSync_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [CW-1:0]      cause_q, cause_d;
    logic [NUM_SRC-1:0] riseDet;
    logic [NUM_SRC-1:0] takeMask;
    logic [CW-1:0]      takeIdx;
    logic               takeCond;

    // Metastability chain per IRQ bit, followed by one flop of history for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                syncChain_q[s] <= '0;
            end
            prevSync_q <= '0;
        end else begin
            syncChain_q[0] <= irq_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncChain_q[s] <= syncChain_q[s-1];
            end
            prevSync_q <= syncChain_q[SYNC_STAGES-1];
        end
    end

    assign riseDet = syncChain_q[SYNC_STAGES-1] & ~prevSync_q;

    // Priority encode the pending vector: lowest set index wins
    always_comb begin
        takeIdx  = '0;
        takeMask = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                takeIdx     = CW'(i);
                takeMask    = '0;
                takeMask[i] = 1'b1;
            end
        end
    end

    assign takeCond = (state_q == S_IDLE) && (|pending_q) && csrMie_i && instrRetire_i;

    // Pending bits clear only for the source being taken; a same-edge new rise wins
    always_comb begin
        pending_d = (pending_q & ~(takeCond ? takeMask : '0)) | riseDet;
        cause_d   = takeCond ? takeIdx : cause_q;
    end

    // Pending vector, last-taken cause and FSM state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state: take, one-cycle redirect, handler until MRET, one-cycle return
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (takeCond) state_d = S_TAKE;
            S_TAKE:    state_d = S_HANDLER;
            S_HANDLER: if (mret_i) state_d = S_RETURN;
            S_RETURN:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Moore output decode; redirect target follows the live CSR values
    always_comb begin
        intTaken_o   = 1'b0;
        stall_o      = 1'b0;
        pcSel_o      = 1'b0;
        pcRedirect_o = 32'h0;
        intActive_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_TAKE: begin
                intTaken_o   = 1'b1;
                stall_o      = 1'b1;
                pcSel_o      = 1'b1;
                pcRedirect_o = csrMtvec_i;
            end
            S_HANDLER: begin
                intActive_o = 1'b1;
            end
            S_RETURN: begin
                pcSel_o      = 1'b1;
                pcRedirect_o = csrMepc_i;
                intActive_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign intCause_o = cause_q;
    assign pending_o  = pending_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a directed vector table, hand-written
// corner sequences, and randomized traffic checked against a behavioural model.
module tb_trap_sequencer;

    localparam int NSRC = 4;
    localparam int SYNC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] irq;
    logic            mie, retire, mret;
    logic [31:0]     mtvec, mepc;
    logic            intTaken, stall, pcSel, intActive;
    logic [31:0]     pcRedirect;
    logic [1:0]      intCause;
    logic [NSRC-1:0] pending;

    int total = 0;
    int bad   = 0;

    trap_sequencer #(.NUM_SRC(NSRC), .SYNC_STAGES(SYNC)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .irq_i(irq),
        .csrMie_i(mie),
        .csrMtvec_i(mtvec),
        .csrMepc_i(mepc),
        .instrRetire_i(retire),
        .mret_i(mret),
        .intTaken_o(intTaken),
        .stall_o(stall),
        .pcSel_o(pcSel),
        .pcRedirect_o(pcRedirect),
        .intActive_o(intActive),
        .intCause_o(intCause),
        .pending_o(pending)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference model: IRQ sample history (newest first), pending set, trap phase flags
    logic [NSRC-1:0] mHist[$];
    logic [NSRC-1:0] mPend;
    logic [1:0]      mCause;
    bit              mInTake, mInHandler, mInReturn;

    typedef struct {
        logic [3:0]  irq;
        logic        mie;
        logic        retire;
        logic        mret;
        logic        expTaken;
        logic        expSel;
        logic        expActive;
        logic [31:0] expRedir;
        logic [1:0]  expCause;
        logic [3:0]  expPend;
    } vec_t;

    vec_t vecs[8];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mHist.delete();
        for (int k = 0; k <= SYNC; k++) mHist.push_back('0);
        mPend      = '0;
        mCause     = '0;
        mInTake    = 0;
        mInHandler = 0;
        mInReturn  = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] i, input logic m, input logic r, input logic mr);
        irq    = i;
        mie    = m;
        retire = r;
        mret   = mr;
    endtask

    // Compare every DUT output with what the model predicts for the current cycle
    task automatic checkOutput(input string tag);
        logic [31:0] expRedir;
        expRedir = mInTake ? mtvec : (mInReturn ? mepc : 32'h0);
        compare({tag, ".taken"},   32'(intTaken),   32'(mInTake));
        compare({tag, ".stall"},   32'(stall),      32'(mInTake));
        compare({tag, ".pcSel"},   32'(pcSel),      32'(mInTake | mInReturn));
        compare({tag, ".redir"},   pcRedirect,      expRedir);
        compare({tag, ".active"},  32'(intActive),  32'(mInHandler | mInReturn));
        compare({tag, ".cause"},   32'(intCause),   32'(mCause));
        compare({tag, ".pending"}, 32'(pending),    32'(mPend));
    endtask

    // Advance one clock: model evaluates with pre-edge inputs, commits after the edge
    task automatic tick(input string tag);
        logic [NSRC-1:0] rise, nPend;
        logic [1:0]      nCause;
        bit              idle, takeNow, nTake, nHand, nRet;
        int              idx;
        rise    = mHist[SYNC-1] & ~mHist[SYNC];
        idle    = !(mInTake || mInHandler || mInReturn);
        takeNow = idle && (mPend != 0) && mie && retire;
        idx = 0;
        while (idx < NSRC && !mPend[idx]) idx++;
        nPend = mPend;
        if (takeNow) nPend[idx] = 1'b0;
        nPend  = nPend | rise;
        nCause = takeNow ? 2'(idx) : mCause;
        nTake  = takeNow;
        nHand  = mInTake || (mInHandler && !mret);
        nRet   = mInHandler && mret;
        @(posedge clk);
        #1;
        mHist.push_front(irq);
        void'(mHist.pop_back());
        mPend      = nPend;
        mCause     = nCause;
        mInTake    = nTake;
        mInHandler = nHand;
        mInReturn  = nRet;
        checkOutput(tag);
    endtask

    initial begin
        int takes;

        // Directed entry/return sequence: MTVEC=0x100, MEPC=0x2C, IRQ[2] rises before edge 1
        vecs[0] = '{4'h4, 1, 1, 0, 0, 0, 0, 32'h0,   2'd0, 4'h0};
        vecs[1] = '{4'h4, 1, 1, 0, 0, 0, 0, 32'h0,   2'd0, 4'h0};
        vecs[2] = '{4'h4, 1, 1, 0, 0, 0, 0, 32'h0,   2'd0, 4'h4};
        vecs[3] = '{4'h4, 1, 1, 0, 1, 1, 0, 32'h100, 2'd2, 4'h0};
        vecs[4] = '{4'h0, 1, 1, 0, 0, 0, 1, 32'h0,   2'd2, 4'h0};
        vecs[5] = '{4'h0, 1, 1, 1, 0, 1, 1, 32'h2C,  2'd2, 4'h0};
        vecs[6] = '{4'h0, 1, 1, 0, 0, 0, 0, 32'h0,   2'd2, 4'h0};
        vecs[7] = '{4'h0, 1, 1, 0, 0, 0, 0, 32'h0,   2'd2, 4'h0};

        rst   = 1'b1;
        mtvec = 32'h100;
        mepc  = 32'h2C;
        applyStimulus(4'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput("reset");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].irq, vecs[i].mie, vecs[i].retire, vecs[i].mret);
            tick($sformatf("vec%0d", i));
            compare($sformatf("vec%0d.taken", i),   32'(intTaken),  32'(vecs[i].expTaken));
            compare($sformatf("vec%0d.stall", i),   32'(stall),     32'(vecs[i].expTaken));
            compare($sformatf("vec%0d.pcSel", i),   32'(pcSel),     32'(vecs[i].expSel));
            compare($sformatf("vec%0d.active", i),  32'(intActive), 32'(vecs[i].expActive));
            compare($sformatf("vec%0d.redir", i),   pcRedirect,     vecs[i].expRedir);
            compare($sformatf("vec%0d.cause", i),   32'(intCause),  32'(vecs[i].expCause));
            compare($sformatf("vec%0d.pending", i), 32'(pending),   32'(vecs[i].expPend));
        end

        // Priority: IRQ 1 and 3 rise together, 1 taken first, 3 after MRET
        applyStimulus(4'b1010, 1, 1, 0);
        repeat (3) tick("prio.sync");
        compare("prio.pendBoth", 32'(pending), 32'h0000000A);
        tick("prio.take1");
        compare("prio.taken1", 32'(intTaken), 32'd1);
        compare("prio.cause1", 32'(intCause), 32'd1);
        applyStimulus(4'b0000, 1, 1, 0);
        repeat (4) tick("prio.hold");
        compare("prio.pendHeld", 32'(pending), 32'h00000008);
        compare("prio.active",   32'(intActive), 32'd1);
        applyStimulus(4'b0000, 1, 1, 1);
        tick("prio.mret");
        applyStimulus(4'b0000, 1, 1, 0);
        tick("prio.idle");
        tick("prio.take3");
        compare("prio.taken3", 32'(intTaken), 32'd1);
        compare("prio.cause3", 32'(intCause), 32'd3);
        tick("prio.hand3");
        applyStimulus(4'b0000, 1, 1, 1);
        tick("prio.mret3");
        applyStimulus(4'b0000, 1, 1, 0);
        repeat (2) tick("prio.settle");

        // Masked: MIE=0 keeps both pends and never takes
        applyStimulus(4'b1010, 0, 1, 0);
        takes = 0;
        for (int i = 0; i < 10; i++) begin
            tick("mask");
            takes += int'(intTaken);
        end
        compare("mask.noTake",  32'(takes),   32'd0);
        compare("mask.pending", 32'(pending), 32'h0000000A);
        applyStimulus(4'b0000, 1, 1, 1);
        repeat (12) tick("mask.drain");
        compare("mask.drained", 32'(pending), 32'd0);

        // Level-held IRQ[0] for 50 cycles pends and is taken exactly once
        applyStimulus(4'b0001, 1, 1, 1);
        takes = 0;
        for (int i = 0; i < 50; i++) begin
            tick("held");
            takes += int'(intTaken);
        end
        compare("held.oneTake", 32'(takes), 32'd1);
        applyStimulus(4'b0000, 1, 0, 0);
        repeat (4) tick("held.settle");

        // Collision: IRQ[0] re-rises on the very edge that takes source 0
        applyStimulus(4'b0001, 1, 0, 0);
        repeat (3) tick("coll.pend");
        applyStimulus(4'b0000, 1, 0, 0);
        repeat (3) tick("coll.low");
        applyStimulus(4'b0001, 1, 0, 0);
        repeat (2) tick("coll.sync");
        applyStimulus(4'b0001, 1, 1, 0);
        tick("coll.take");
        compare("coll.taken",   32'(intTaken),   32'd1);
        compare("coll.cause",   32'(intCause),   32'd0);
        compare("coll.pend0",   32'(pending[0]), 32'd1);
        applyStimulus(4'b0000, 1, 1, 1);
        repeat (10) tick("coll.drain");
        applyStimulus(4'b0000, 1, 0, 0);
        repeat (2) tick("coll.settle");

        // No retire: pending source waits for a legal take point
        applyStimulus(4'b0100, 1, 0, 0);
        repeat (3) tick("noret.pend");
        takes = 0;
        for (int i = 0; i < 10; i++) begin
            tick("noret.wait");
            takes += int'(intTaken);
        end
        compare("noret.noTake", 32'(takes), 32'd0);
        applyStimulus(4'b0000, 1, 1, 0);
        tick("noret.take");
        compare("noret.taken", 32'(intTaken), 32'd1);
        compare("noret.cause", 32'(intCause), 32'd2);
        tick("noret.hand");
        compare("noret.inHandler", 32'(intActive), 32'd1);

        // Asynchronous reset mid-handler, no clock edge in between
        #2;
        rst = 1'b1;
        #1;
        compare("arst.taken",   32'(intTaken),  32'd0);
        compare("arst.pcSel",   32'(pcSel),     32'd0);
        compare("arst.redir",   pcRedirect,     32'd0);
        compare("arst.active",  32'(intActive), 32'd0);
        compare("arst.cause",   32'(intCause),  32'd0);
        compare("arst.pending", 32'(pending),   32'd0);
        #1;
        rst = 1'b0;
        modelReset();
        tick("arst.after");

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [3:0] nIrq;
            nIrq = irq;
            if ($urandom_range(0, 5) == 0) nIrq = nIrq ^ 4'($urandom);
            applyStimulus(nIrq, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) == 0);
            mtvec = $urandom;
            mepc  = $urandom;
            #1;
            checkOutput("rand.comb");
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
